// File: rtl/instruction_sequencer_if.sv
// Bus/handshake bundle between the instruction sequencer and its datapath.
// The sequencer side uses the master modport, the datapath side uses slave.
interface instruction_sequencer_if;
   logic [15:0] in_ir;
   logic [3:0]  in_alu_flags;
   logic        in_mem_ready;
   logic        in_run;
   logic        in_step;

   logic        out_ir_load;
   logic        out_pc_inc;
   logic        out_pc_load;
   logic        out_alu_enable_out;
   logic        out_reg_read_en;
   logic        out_data_memory_read_enable;
   logic        out_reg_write_en;
   logic        out_data_memory_wr_enable;
   logic        out_data_memory_addr_wr_enable;
   logic        out_mbs_wr_enable;
   logic [2:0]  out_state;
   logic        out_halted;
   logic        out_fault;
   logic [7:0]  out_retired;

   modport master (
      input  in_ir, in_alu_flags, in_mem_ready, in_run, in_step,
      output out_ir_load, out_pc_inc, out_pc_load,
      output out_alu_enable_out, out_reg_read_en, out_data_memory_read_enable,
      output out_reg_write_en, out_data_memory_wr_enable,
      output out_data_memory_addr_wr_enable, out_mbs_wr_enable,
      output out_state, out_halted, out_fault, out_retired
   );

   modport slave (
      output in_ir, in_alu_flags, in_mem_ready, in_run, in_step,
      input  out_ir_load, out_pc_inc, out_pc_load,
      input  out_alu_enable_out, out_reg_read_en, out_data_memory_read_enable,
      input  out_reg_write_en, out_data_memory_wr_enable,
      input  out_data_memory_addr_wr_enable, out_mbs_wr_enable,
      input  out_state, out_halted, out_fault, out_retired
   );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: fetch / load IR / execute / memory wait,
// with run/step control, memory timeout fault and a retired-instruction count.
module instruction_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   instruction_sequencer_if.master   bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      LOAD_IR  = 3'd2,
      EXEC     = 3'd3,
      MEM_WAIT = 3'd4,
      HALT     = 3'd5
   } state_t;

   localparam logic [4:0] OP_NOP     = 5'b00000;
   localparam logic [4:0] OP_LOAD    = 5'b01000;
   localparam logic [4:0] OP_STORE   = 5'b01001;
   localparam logic [4:0] OP_SETBANK = 5'b01010;
   localparam logic [4:0] OP_HALT    = 5'b11111;
   localparam logic [3:0] WAIT_LAST  = 4'(MEM_TIMEOUT - 1);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        mem_store;
   logic        fault;
   logic [7:0]  retired;

   logic [4:0]  opcode;
   logic        op_nop, op_alu, op_mem, op_setbank, op_halt, op_jump;
   logic        jump_taken, op_retire;
   logic        unused_bits;

   assign opcode      = bus.in_ir[15:11];
   assign unused_bits = ^{bus.in_ir[10:0], bus.in_alu_flags[3]};

   always_comb begin
      op_nop     = (opcode == OP_NOP);
      op_alu     = (opcode >= 5'd1) && (opcode <= 5'd7);
      op_mem     = (opcode == OP_LOAD) || (opcode == OP_STORE);
      op_setbank = (opcode == OP_SETBANK);
      op_halt    = (opcode == OP_HALT);
      op_jump    = (opcode[4:2] == 3'b100);
      op_retire  = op_nop || op_alu || op_setbank || op_jump;
      case (opcode)
         5'b10000: jump_taken = 1'b1;
         5'b10001: jump_taken = bus.in_alu_flags[0];
         5'b10010: jump_taken = bus.in_alu_flags[2];
         5'b10011: jump_taken = bus.in_alu_flags[1];
         default:  jump_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         mem_store <= 1'b0;
         fault     <= 1'b0;
         retired   <= '0;
      end else begin
         case (state)
            IDLE:    if (bus.in_run || bus.in_step) state <= FETCH;
            FETCH:   state <= LOAD_IR;
            LOAD_IR: state <= EXEC;
            EXEC: begin
               if (op_mem) begin
                  state     <= MEM_WAIT;
                  wait_cnt  <= '0;
                  mem_store <= opcode[0];
               end else if (op_halt) begin
                  state <= HALT;
               end else if (op_retire) begin
                  retired <= retired + 8'd1;
                  state   <= bus.in_run ? FETCH : IDLE;
               end else begin
                  fault <= 1'b1;
                  state <= HALT;
               end
            end
            MEM_WAIT: begin
               if (bus.in_mem_ready) begin
                  retired <= retired + 8'd1;
                  state   <= bus.in_run ? FETCH : IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  fault <= 1'b1;
                  state <= HALT;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            HALT:    state <= HALT;
            default: begin
               fault <= 1'b1;
               state <= HALT;
            end
         endcase
      end
   end

   // Strobes are Mealy: registered state plus the live IR, flags and mem_ready.
   always_comb begin
      bus.out_ir_load                    = 1'b0;
      bus.out_pc_inc                     = 1'b0;
      bus.out_pc_load                    = 1'b0;
      bus.out_alu_enable_out             = 1'b0;
      bus.out_reg_read_en                = 1'b0;
      bus.out_data_memory_read_enable    = 1'b0;
      bus.out_reg_write_en               = 1'b0;
      bus.out_data_memory_wr_enable      = 1'b0;
      bus.out_data_memory_addr_wr_enable = 1'b0;
      bus.out_mbs_wr_enable              = 1'b0;
      case (state)
         LOAD_IR: begin
            bus.out_ir_load = 1'b1;
            bus.out_pc_inc  = 1'b1;
         end
         EXEC: begin
            if (op_alu) begin
               bus.out_alu_enable_out = 1'b1;
               bus.out_reg_write_en   = 1'b1;
            end
            if (op_setbank) bus.out_mbs_wr_enable = 1'b1;
            if (op_mem) begin
               bus.out_reg_read_en                = 1'b1;
               bus.out_data_memory_addr_wr_enable = 1'b1;
            end
            if (jump_taken) bus.out_pc_load = 1'b1;
         end
         MEM_WAIT: begin
            if (mem_store) begin
               bus.out_reg_read_en           = 1'b1;
               bus.out_data_memory_wr_enable = bus.in_mem_ready;
            end else begin
               bus.out_data_memory_read_enable = 1'b1;
               bus.out_reg_write_en            = bus.in_mem_ready;
            end
         end
         default: ;
      endcase
   end

   assign bus.out_state   = state;
   assign bus.out_halted  = (state == HALT);
   assign bus.out_fault   = fault;
   assign bus.out_retired = retired;
endmodule
